// File: rtl/alu_muldiv.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one step per clock, then a sign-fix cycle.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   quo_reg, quo_next;
  logic [WIDTH-1:0]   opb_reg, opb_next;
  logic [WIDTH-1:0]   araw_reg, araw_next;
  logic               is_div_reg, is_div_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic               bzero_reg, bzero_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg, done_next;
  logic               dbz_reg, dbz_next;

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Magnitude of the most-negative value is naturally 2^(WIDTH-1) when read unsigned.
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

  assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, opb_reg};
  assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb_reg};

  assign mul_fix   = neg_q_reg ? -prod_reg : prod_reg;
  assign quo_fix   = neg_q_reg ? -quo_reg : quo_reg;
  assign rem_fix   = neg_r_reg ? -rem_reg : rem_reg;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    prod_next   = prod_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    opb_next    = opb_reg;
    araw_next   = araw_reg;
    is_div_next = is_div_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    bzero_next  = bzero_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    dbz_next    = dbz_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_next = op[1];
              // Multiplier sits in the low half of the product; dividend shifts out of quo.
              prod_next   = {{WIDTH{1'b0}}, b_mag};
              quo_next    = a_mag;
              rem_next    = '0;
              opb_next    = op[1] ? b_mag : a_mag;
              araw_next   = a;
              neg_q_next  = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r_next  = op_signed && a[WIDTH-1];
              bzero_next  = (b == '0);
              cnt_next    = '0;
              state_next  = CALC;
            end
            OP_MTHI: begin
              hi_next   = a;
              done_next = 1'b1;
            end
            OP_MTLO: begin
              lo_next   = a;
              done_next = 1'b1;
            end
            default: ;
          endcase
        end
      end

      CALC: begin
        if (is_div_reg) begin
          quo_next = {quo_reg[WIDTH-2:0], div_ge};
          rem_next = div_ge ? (div_shift[WIDTH-1:0] - opb_reg) : div_shift[WIDTH-1:0];
        end else begin
          prod_next = prod_reg[0] ? {mul_sum, prod_reg[WIDTH-1:1]}
                                  : {1'b0, prod_reg[2*WIDTH-1:1]};
        end
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end

      FIX: begin
        if (is_div_reg) begin
          if (bzero_reg) begin
            lo_next  = '1;
            hi_next  = araw_reg;
            dbz_next = 1'b1;
          end else begin
            lo_next  = quo_fix;
            hi_next  = rem_fix;
            dbz_next = 1'b0;
          end
        end else begin
          {hi_next, lo_next} = mul_fix;
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      prod_reg   <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      opb_reg    <= '0;
      araw_reg   <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      bzero_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      prod_reg   <= prod_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      opb_reg    <= opb_next;
      araw_reg   <= araw_next;
      is_div_reg <= is_div_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      bzero_reg  <= bzero_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_reg   <= done_next;
      dbz_reg    <= dbz_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes expected HI/LO/flag, a monitor pops on done.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W), .CNT_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    string        name;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;
  logic         model_dbz = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [W-1:0] eh, input logic [W-1:0] el,
                      input logic ed);
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ed; e.name = name;
    sb.push_back(e);
    model_hi = eh; model_lo = el; model_dbz = ed;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done in 100 cycles required done", name);
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                     input logic ed);
    push(name, eh, el, ed);
    issue(o, x, y);
    wait_done(name);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && done) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 required no pending result");
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          check({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
          check({e.name, "_busy_at_done"}, 64'(busy), 64'(0));
          $display("[TB] %s hi=0x%08h lo=0x%08h dbz=%0b", e.name, hi, lo, div_by_zero);
        end
      end
    end
  end

  initial begin
    int busy_cnt;
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    reset_n = 1'b1;

    // MULTU max*max, with busy duration measured.
    push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_cnt = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
      n++;
    end
    check("multu_max_busy_cycles", 64'(busy_cnt), 64'(33));

    run("mult_neg",  3'b000, 32'd10, 32'hFFFF_FFDD, 32'hFFFF_FFFF, 32'hFFFF_FEA2, 1'b0);
    run("multu_neg", 3'b001, 32'd10, 32'hFFFF_FFDD, 32'h0000_0009, 32'hFFFF_FEA2, 1'b0);
    run("div_m7_2",  3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("div_7_m2",  3'b010, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run("divu_7_2",  3'b011, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run("divu_by0",  3'b011, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    run("div_by0",   3'b010, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
    run("mthi",      3'b100, 32'h0000_1357, 32'd0, 32'h0000_1357, model_lo, 1'b1);
    run("divu_9_3",  3'b011, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

    // Second start during a MULT must be ignored.
    push("mult_hs", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    issue(3'b000, 32'hFFFF_FFFD, 32'd5);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'b001; a = 32'd100; b = 32'd100;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("mult_hs");
    repeat (40) @(negedge clk);

    // MTLO while idle: busy never rises.
    push("mtlo", model_hi, 32'h0000_CAFE, model_dbz);
    issue(3'b101, 32'h0000_CAFE, 32'd0);
    check("mtlo_busy", 64'(busy), 64'(0));
    wait_done("mtlo");

    // Reserved op: nothing happens.
    issue(3'b110, 32'h1111_1111, 32'h2222_2222);
    check("rsvd_busy", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-CALC.
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_hi", 64'(hi), 64'(0));
    check("rst_mid_lo", 64'(lo), 64'(0));
    model_hi = '0; model_lo = '0; model_dbz = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    run("multu_3x5", 3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    repeat (3) @(negedge clk);
    check("sb_pending", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, multi-cycle multiply/divide unit beside the combinational Shift/Logic/Arith ALU.
- Executes MIPS-style MULT/MULTU/DIV/DIVU into internal HI/LO registers, plus MTHI/MTLO.
- Uses a start/busy/done handshake so the pipeline can stall on it.
- HI/LO are continuously readable for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width and HI/LO register width; legal range 4..64.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only while busy=0.
- op  in  3  operation code, sampled with start: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- a  in  WIDTH  operand A (multiplicand, dividend, or MTHI/MTLO data); sampled with start.
- b  in  WIDTH  operand B (multiplier or divisor); sampled with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO hold a new result.
- div_by_zero  out  1  sticky flag: last DIV/DIVU had b=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset_n low, takes effect immediately without waiting for a clock edge):
  - state=IDLE; busy, done, div_by_zero = 0; hi, lo = 0; counter = 0.
  - Reset mid-operation aborts the operation; no done pulse is issued.
- State machine: IDLE, CALC, FIX.
- IDLE:
  - On an edge with start=1 and op in MULT..DIVU: latch operand magnitudes and sign info, clear the accumulator, counter=0, go to CALC.
  - MULT/DIV take magnitudes of two's-complement a and b. MULTU/DIVU use a and b raw.
- CALC: one radix-2 step per cycle for exactly WIDTH cycles.
  - Multiply: shift-add on a 2*WIDTH-bit product register.
  - Divide: restoring shift-subtract on a (WIDTH+1)-bit partial remainder.
  - On counter == WIDTH-1: go to FIX.
- FIX: one cycle.
  - Negate the product if sign(a) XOR sign(b) (signed multiply only).
  - Signed divide: quotient negated if signs differ; remainder takes the sign of the dividend.
  - On the exiting edge write hi/lo, go to IDLE, and drive done=1 for exactly the following cycle.
- Results:
  - MULT/MULTU: {hi, lo} = full 2*WIDTH-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Latency:
  - start sampled at edge k → busy=1 from edge k through edge k+WIDTH+1.
  - hi/lo updated and done=1 after edge k+WIDTH+1; busy=0 in the same cycle.
  - A new start may be sampled on edge k+WIDTH+2 (the done cycle), giving back-to-back throughput of WIDTH+2 cycles.
- MTHI/MTLO:
  - Single cycle: hi (or lo) = a on the sampling edge.
  - busy stays 0; done pulses for the following cycle.
  - The other register is unchanged.
- Reserved op with start=1: ignored; no state change and no done.
- start while busy=1: ignored, not queued; operands and op may change freely.
- Division by zero (b=0):
  - Runs the normal WIDTH+1 cycles.
  - Result: lo = all ones, hi = a (unsigned view of the raw dividend for both DIV and DIVU); div_by_zero=1.
  - Any subsequent DIV/DIVU with b≠0 clears the flag at its done. MULT/MT* leave the flag unchanged.
- Signed overflow case, DIV with a = most-negative and b = -1:
  - lo = most-negative (wraps), hi = 0.
  - No flag is raised.
- Magnitude of the most-negative value is handled as the unsigned 2^(WIDTH-1); there is no internal overflow.
- hi/lo hold their values between operations and are never modified during CALC/FIX. Readers see the old values until done.

Test Plan:
- MULTU, WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=10, b=-35 (0xFFFFFFDD) → hi=0xFFFFFFFF, lo=0xFFFFFEA2 (-350); MULTU on the same operands → hi=0x00000009, lo=0xFFFFFEA2.
- DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=2 → lo=3, hi=1; DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1; then DIVU a=9, b=3 → lo=3, hi=0, div_by_zero=0.
- Handshake:
  - start pulsed again at cycle 5 of a MULT with different operands → ignored; exactly one done, result from the first operands.
  - MTLO a=0xCAFE while idle → lo=0xCAFE next cycle, hi unchanged, busy never set.
- Reset: assert reset_n=0 mid-CALC (cycle 10) between clock edges → busy=0, hi=lo=0 immediately; no done after release; a fresh MULTU 3×5 then yields lo=15, hi=0.
